prbs_checker: RTL
=================

// Module: prbs_checker
// PURPOSE
//  Serial receiver/checker for the 32-bit Fibonacci PRNG stream (x^32+x^22+x^2+x^1, new bit at pos 1).
//  Self-synchronises to the incoming bit stream, declares lock, then counts bit errors vs predicted sequence.
//  Sits at the far end of a PRNG link (loopback/BER test); feeds status to LEDs/host readout.
// PARAMETERS
//  N          32   LFSR length; taps fixed at 32,22,2,1 -> only N=32 supported
//  SYNC_LEN   64   consecutive matching bits in VERIFY needed to declare lock
//  WINDOW     256  bits per loss-of-lock evaluation window (LOCKED only)
//  ERR_THRESH 8    errors within one WINDOW that drop lock
//  CNT_W      32   width of err_cnt and bit_cnt
// PORTS
//  clk        in   1      clock, rising edge
//  reset_n    in   1      async, active-low reset
//  din        in   1      received PRNG bit (successive Q[1] values of the generator)
//  din_valid  in   1      din sampled on rising clk when 1; no action when 0
//  clr_cnt    in   1      sync clear of err_cnt and bit_cnt
//  locked     out  1      1 while in LOCKED state
//  err        out  1      1-cycle pulse: last valid bit mismatched prediction (LOCKED only)
//  err_cnt    out  CNT_W  saturating count of errors seen in LOCKED
//  bit_cnt    out  CNT_W  saturating count of valid bits checked in LOCKED
//  stuck      out  1      all-zero lock-up detected (tied 0 when PRBS_CHK_ZERO_DET_EN undefined)
// BEHAVIOUR
//  Reset: state=FILL, sr[1:32]=0, fill/match/window counters=0, all outputs 0. Async assert, sync-free release.
//  pred = sr[32]^sr[22]^sr[2]^sr[1] (combinational, from current sr). All actions only when din_valid=1.
//  FILL: sr <= {din, sr[1:31]}; after 32nd valid bit -> VERIFY, match_cnt=0. No compare, err=0.
//  VERIFY: compare din vs pred; sr <= {din, sr[1:31]} (self-sync).
//   match -> match_cnt+1; when match_cnt reaches SYNC_LEN -> LOCKED, win_cnt=0, win_err=0.
//   mismatch -> match_cnt=0, stay VERIFY (sr already realigned by loading din).
//  LOCKED: sr <= {pred, sr[1:31]} (free-running reference; one flipped bit counts once).
//   bit_cnt+1; mismatch -> err=1 next cycle, err_cnt+1, win_err+1.
//   win_err (incl. current) >= ERR_THRESH -> FILL, fill_cnt=0, locked=0 next cycle.
//   win_cnt reaching WINDOW (incl. current) -> win_cnt=0, win_err=0 (threshold check first).
//  Latency: err/locked/counters update on the clk edge sampling the valid bit (visible next cycle).
//  Lock time from reset with clean stream: 32+SYNC_LEN = 96 valid bits.
//  Counters saturate at all-ones, never wrap. clr_cnt same cycle as increment: clear wins (->0).
//  clr_cnt does not affect state, sr, locked or window counters.
//  din_valid=0: all state held, err=0.
// CONFIGURATION
//  PRBS_CHK_ZERO_DET_EN defined: in VERIFY/LOCKED, sr==0 after update -> state FILL, stuck=1 (sticky
//   until reset or clr_cnt); prevents false lock on all-zero stream (zeros satisfy the recurrence).
//  Undefined: no detection, stuck tied 0; all-zero stream locks after 96 bits with err_cnt=0.
// STRUCTURE
//  Package prbs_pkg: N, tap positions (32,22,2,1), state encoding (FILL/VERIFY/LOCKED),
//   function prbs_pred(sr) returning next bit; shared with the generator side.
//  Sub-module prbs_sat_counter (CNT_W, inc, clr, clr-wins) instanced for err_cnt and bit_cnt.
//  FSM, sr and window logic in prbs_checker top.
// TESTING (reference stream: lfsr generator, seed 1, din = its Q[1] each cycle, din_valid=1)
//  Clean stream from reset -> locked rises after 96th valid bit; err never 1; err_cnt=0.
//  After lock, invert one bit -> single err pulse, err_cnt=1, locked stays 1, bit_cnt keeps counting.
//  After lock, invert 8 bits within 256 -> locked falls after 8th error; relocks 96 bits later.
//  din_valid toggled 1/0 every cycle -> lock after 96 valid bits (~192 cycles); counts unchanged by gaps.
//  clr_cnt asserted same cycle as an error -> err_cnt=0 next cycle; locked unaffected.
//  All-zero din: with PRBS_CHK_ZERO_DET_EN stuck=1, locked never 1; without, locked after 96 bits.
//  reset_n low mid-LOCKED -> locked, err, counters 0 immediately (async); relock 96 bits after release.

Source files
------------

// File: rtl/prbs_pkg.sv
// Shared definitions for the 32-bit Fibonacci PRBS link (x^32+x^22+x^2+x^1).
// Used by both the generator and the checker side.
package prbs_pkg;

    // LFSR length and tap positions; the new bit enters at position 1.
    localparam int N     = 32;
    localparam int TAP_A = 32;
    localparam int TAP_B = 22;
    localparam int TAP_C = 2;
    localparam int TAP_D = 1;

    // Default checker tuning.
    localparam int DEF_SYNC_LEN   = 64;
    localparam int DEF_WINDOW     = 256;
    localparam int DEF_ERR_THRESH = 8;
    localparam int DEF_CNT_W      = 32;

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // Next PRBS bit predicted from the current register contents.
    function automatic logic prbs_pred(input logic [1:N] sr);
        return sr[TAP_A] ^ sr[TAP_B] ^ sr[TAP_C] ^ sr[TAP_D];
    endfunction

endpackage

// File: rtl/prbs_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module prbs_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    // Count up to all-ones and hold there; clr forces zero.
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + {{(W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS-32 receiver: fills its register from the stream,
// verifies SYNC_LEN consecutive predictions, then runs a free-running reference
// and counts bit errors, dropping lock on ERR_THRESH errors within a WINDOW.
// Optional all-zero lock-up detection: define PRBS_CHK_ZERO_DET_EN.
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int SYNC_LEN   = DEF_SYNC_LEN,
    parameter int WINDOW     = DEF_WINDOW,
    parameter int ERR_THRESH = DEF_ERR_THRESH,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             din,
    input  logic             din_valid,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             stuck
);

    localparam int FILL_W  = $clog2(N + 1);
    localparam int MATCH_W = $clog2(SYNC_LEN + 1);
    localparam int WIN_W   = $clog2(WINDOW + 1);
    localparam int WERR_W  = $clog2(ERR_THRESH + 1);

    state_t              state_q, state_d;
    logic [1:N]          sr_q, sr_d;
    logic [FILL_W-1:0]   fill_cnt_q;
    logic [MATCH_W-1:0]  match_cnt_q;
    logic [WIN_W-1:0]    win_cnt_q;
    logic [WERR_W-1:0]   win_err_q;

    logic pred, mismatch;
    logic lock_chk, lock_err;
    logic fill_done, sync_done, thresh_hit, win_end, zero_hit;

    // Prediction, compare and event decode for the current valid bit.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        pred       = prbs_pred(sr_q);
        mismatch   = din ^ pred;
        lock_chk   = din_valid && (state_q == ST_LOCKED);
        lock_err   = lock_chk && mismatch;
        fill_done  = din_valid && (state_q == ST_FILL) && (fill_cnt_q == FILL_W'(N - 1));
        sync_done  = din_valid && (state_q == ST_VERIFY) && !mismatch
                     && (match_cnt_q == MATCH_W'(SYNC_LEN - 1));
        thresh_hit = lock_err && (win_err_q >= WERR_W'(ERR_THRESH - 1));
        win_end    = lock_chk && (win_cnt_q == WIN_W'(WINDOW - 1));
        // Locked: free-running reference; otherwise realign on the received bit.
        sr_d = sr_q;
        if (din_valid) begin
            sr_d = {(state_q == ST_LOCKED) ? pred : din, sr_q[1:N-1]};
        end
`ifdef PRBS_CHK_ZERO_DET_EN
        zero_hit = din_valid && (state_q != ST_FILL) && (sr_d == '0);
`else
        zero_hit = 1'b0;
`endif
    end

    // State register.
    // NOTE: reset is asynchronous and active-low; release needs no synchronisation here.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_FILL;
        else          state_q <= state_d;
    end

    // Next-state logic; an all-zero register always forces a refill.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FILL:   if (fill_done)  state_d = ST_VERIFY;
            ST_VERIFY: if (sync_done)  state_d = ST_LOCKED;
            ST_LOCKED: if (thresh_hit) state_d = ST_FILL;
            default:                   state_d = ST_FILL;
        endcase
        if (zero_hit) state_d = ST_FILL;
    end

    // Outputs decoded from the current state.
    always_comb begin
        locked = (state_q == ST_LOCKED);
    end

    // Shift register, fill/match/window counters and the error pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr_q        <= '0;
            fill_cnt_q  <= '0;
            match_cnt_q <= '0;
            win_cnt_q   <= '0;
            win_err_q   <= '0;
            err         <= 1'b0;
        end else begin
            sr_q <= sr_d;
            err  <= lock_err;
            if (din_valid) begin
                case (state_q)
                    ST_FILL:   fill_cnt_q  <= fill_done ? '0 : fill_cnt_q + FILL_W'(1);
                    ST_VERIFY: match_cnt_q <= mismatch ? '0 : match_cnt_q + MATCH_W'(1);
                    ST_LOCKED: begin
                        if (win_end) begin
                            win_cnt_q <= '0;
                            win_err_q <= '0;
                        end else begin
                            win_cnt_q <= win_cnt_q + WIN_W'(1);
                            win_err_q <= win_err_q + WERR_W'(lock_err);
                        end
                    end
                    default: ;
                endcase
                if (fill_done) match_cnt_q <= '0;
                if (sync_done) begin
                    win_cnt_q <= '0;
                    win_err_q <= '0;
                end
                if ((state_d == ST_FILL) && (state_q != ST_FILL)) fill_cnt_q <= '0;
            end
        end
    end

`ifdef PRBS_CHK_ZERO_DET_EN
    // Sticky lock-up flag; a fresh detection beats a simultaneous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     stuck <= 1'b0;
        else if (zero_hit) stuck <= 1'b1;
        else if (clr_cnt)  stuck <= 1'b0;
    end
`else
    assign stuck = 1'b0;
`endif

    prbs_sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (lock_err),
        .clr     (clr_cnt),
        .cnt     (err_cnt)
    );

    prbs_sat_counter #(.W(CNT_W)) u_bit_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (lock_chk),
        .clr     (clr_cnt),
        .cnt     (bit_cnt)
    );

endmodule
